mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm_pkg.sv | 43 ++++
 rtl/mc_control_fsm_if.sv | 25 ++
 rtl/mc_control_fsm_mem_wait_timer.sv | 23 ++
 rtl/mc_control_fsm.sv | 130 +++++++++++++
 tb/tb_mc_control_fsm.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle control units: state codes,
// opcodes, ALU operation codes and datapath mux selects.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ERROR  = 4'd10
  } state_e;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that block on the memory handshake and are covered by the timeout
  function automatic logic is_mem_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle controller (master) and datapath (slave).
interface mc_control_fsm_if;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done;
  logic       fault;
  logic [3:0] state_dbg;

  modport master (
    input  Op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, fault, state_dbg
  );

  modport slave (
    output Op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, fault, state_dbg
  );
endinterface

// File: rtl/mc_control_fsm_mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory-wait state and flags the
// cycle in which one more not-ready cycle would exceed the timeout budget.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  logic [7:0] cnt;

  // Wait counter: cleared on reset or whenever the wait episode ends, saturates at 255
  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt <= 8'd0;
    else if (count_en && cnt != 8'hFF)
      cnt <= cnt + 8'd1;
  end

  assign expired = count_en && (cnt == 8'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle datapath controller: Moore FSM with memory-ready gating on
// the fetch/store strobes and a wait timeout that traps to a sticky ERROR.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  mc_control_fsm_if.master       bus
);
  state_e state, next;
  logic   wait_en, wait_clr, expired;

  // A wait episode lasts while a memory state sees not-ready; anything else restarts it
  assign wait_en  = is_mem_wait(state) && !bus.mem_ready;
  assign wait_clr = !wait_en || (next != state);

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (wait_clr),
    .count_en (wait_en),
    .expired  (expired)
  );

  // State register; reset overrides every state, including ERROR
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  // Next-state and output decode of the registered state
  always_comb begin
    next             = state;
    bus.PCWrite      = 1'b0;
    bus.PCWriteCond  = 1'b0;
    bus.IorD         = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.MemtoReg     = 1'b0;
    bus.RegDst       = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.ALUSrcA      = 1'b0;
    bus.ALUSrcB      = SRCB_REG;
    bus.ALUOp        = ALUOP_ADD;
    bus.PCSource     = PCSRC_ALU;
    bus.instr_done   = 1'b0;
    bus.fault        = 1'b0;
    bus.state_dbg    = state;
    case (state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        if (bus.mem_ready) next = S_DECODE;
        else if (expired)  next = S_ERROR;
      end
      S_DECODE: begin
        bus.ALUSrcB = SRCB_BOFF;
        case (bus.Op)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_R:         next = S_EXEC;
          OP_BEQ:       next = S_BRANCH;
          OP_J:         next = S_JUMP;
          default:      next = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        if (bus.Op == OP_LW)      next = S_MEMRD;
        else if (bus.Op == OP_SW) next = S_MEMWR;
        else                      next = S_ERROR;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.mem_ready) next = S_MEMWB;
        else if (expired)  next = S_ERROR;
      end
      S_MEMWB: begin
        bus.RegWrite   = 1'b1;
        bus.MemtoReg   = 1'b1;
        bus.instr_done = 1'b1;
        next           = S_FETCH;
      end
      S_MEMWR: begin
        bus.MemWrite   = 1'b1;
        bus.IorD       = 1'b1;
        bus.instr_done = bus.mem_ready;
        if (bus.mem_ready) next = S_FETCH;
        else if (expired)  next = S_ERROR;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALUOP_FUNCT;
        next        = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite   = 1'b1;
        bus.RegDst     = 1'b1;
        bus.instr_done = 1'b1;
        next           = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = ALUOP_SUB;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = PCSRC_ALUOUT;
        bus.instr_done  = 1'b1;
        next            = S_FETCH;
      end
      S_JUMP: begin
        bus.PCWrite    = 1'b1;
        bus.PCSource   = PCSRC_JUMP;
        bus.instr_done = 1'b1;
        next           = S_FETCH;
      end
      S_ERROR: begin
        bus.fault = 1'b1;
      end
      default: begin
        next = S_ERROR;
      end
    endcase
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: a vector table for the instruction
// flows plus hand sequences for error, timeout and reset corner cases.
module tb_mc_control_fsm;
  logic clk = 1'b0;
  logic reset;

  mc_control_fsm_if bus ();

  mc_control_fsm #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB[2],ALUOp[2],PCSource[2],instr_done,fault}
  logic [17:0] ctl;
  assign ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.instr_done, bus.fault};

  localparam logic [17:0] F_R = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] F_W = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] DEC = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] MA  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] MRD = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] MWB = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] WRW = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] WRD = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] EX  = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] AWB = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] BR  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] JMP = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] ERR = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  localparam logic [3:0] FE = 4'd0, DE = 4'd1, MAD = 4'd2, MR = 4'd3, MW = 4'd4,
                         WR = 4'd5, EXE = 4'd6, AW = 4'd7, BRA = 4'd8, JU = 4'd9,
                         ER = 4'd10;
  localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BQ = 6'h04, JJ = 6'h02;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [17:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [17:0] c);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.ctl = c;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, compare the decoded outputs before the next edge
  task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                      input logic [3:0] es, input logic [17:0] ec, input int tag);
    @(negedge clk);
    reset = r; bus.Op = op; bus.mem_ready = rdy;
    #1;
    checks++;
    if ({bus.state_dbg, ctl} !== {es, ec}) begin
      errors++;
      $display("FAIL step %0d: got state %0d ctl %b, want state %0d ctl %b",
               tag, bus.state_dbg, ctl, es, ec);
    end
  endtask

  initial begin
    reset = 1'b1; bus.Op = 6'h00; bus.mem_ready = 1'b0;

    // reset state, then lw with no waits: 0,1,2,3,4
    add(1, RT, 0, FE, F_W);
    add(0, LW, 1, FE, F_R);  add(0, LW, 1, DE, DEC); add(0, LW, 1, MAD, MA);
    add(0, LW, 1, MR, MRD);  add(0, LW, 1, MW, MWB);
    // sw with three not-ready cycles in MEMWR: 7 cycles total
    add(0, SW, 1, FE, F_R);  add(0, SW, 1, DE, DEC); add(0, SW, 1, MAD, MA);
    add(0, SW, 0, WR, WRW);  add(0, SW, 0, WR, WRW); add(0, SW, 0, WR, WRW);
    add(0, SW, 1, WR, WRD);
    // R-type
    add(0, RT, 1, FE, F_R);  add(0, RT, 1, DE, DEC); add(0, RT, 1, EXE, EX);
    add(0, RT, 1, AW, AWB);
    // beq then j back to back
    add(0, BQ, 1, FE, F_R);  add(0, BQ, 1, DE, DEC); add(0, BQ, 1, BRA, BR);
    add(0, JJ, 1, FE, F_R);  add(0, JJ, 1, DE, DEC); add(0, JJ, 1, JU, JMP);
    // lw with two fetch waits and one read wait
    add(0, LW, 0, FE, F_W);  add(0, LW, 0, FE, F_W); add(0, LW, 1, FE, F_R);
    add(0, LW, 1, DE, DEC);  add(0, LW, 1, MAD, MA); add(0, LW, 0, MR, MRD);
    add(0, LW, 1, MR, MRD);  add(0, LW, 0, MW, MWB);

    @(negedge clk);
    @(negedge clk);
    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].st, vecs[i].ctl, i);

    // illegal opcode traps to a sticky ERROR regardless of inputs
    step(0, LW, 1, FE, F_R, 300);
    step(0, 6'h3F, 1, DE, DEC, 301);
    for (int i = 0; i < 20; i++) begin
      logic [5:0] rop;
      logic       rrdy;
      rop  = 6'($urandom);
      rrdy = 1'($urandom_range(0, 1));
      step(0, rop, rrdy, ER, ERR, 302 + i);
    end
    step(1, RT, 1, ER, ERR, 330);

    // fetch timeout: 16 not-ready cycles then ERROR
    for (int i = 0; i < 16; i++) step(0, RT, 0, FE, F_W, 400 + i);
    step(0, RT, 0, ER, ERR, 420);
    step(1, RT, 0, ER, ERR, 421);

    // ready in the 16th cycle wins over the timeout
    for (int i = 0; i < 15; i++) step(0, LW, 0, FE, F_W, 500 + i);
    step(0, LW, 1, FE, F_R, 515);
    step(0, LW, 1, DE, DEC, 516);
    step(0, LW, 1, MAD, MA, 517);

    // reset while waiting in MEMRD: back to FETCH, no register write
    for (int i = 0; i < 3; i++) step(0, LW, 0, MR, MRD, 600 + i);
    step(1, LW, 0, MR, MRD, 603);

    // reset clears the counter even when the state does not change
    for (int i = 0; i < 10; i++) step(0, LW, 0, FE, F_W, 700 + i);
    step(1, LW, 0, FE, F_W, 710);
    for (int i = 0; i < 16; i++) step(0, LW, 0, FE, F_W, 720 + i);
    step(0, LW, 0, ER, ERR, 740);
    step(1, LW, 0, ER, ERR, 741);

    // MEMRD timeout
    step(0, LW, 1, FE, F_R, 800);
    step(0, LW, 1, DE, DEC, 801);
    step(0, LW, 1, MAD, MA, 802);
    for (int i = 0; i < 16; i++) step(0, LW, 0, MR, MRD, 810 + i);
    step(0, LW, 1, ER, ERR, 830);
    step(1, LW, 1, ER, ERR, 831);
    step(0, LW, 1, FE, F_R, 832);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
